reg_file_mp: RTL
================

# reg_file_mp

Parametrised multi-port register file with integrated scoreboard, the next-generation general-purpose register array for the pipelined CPU core. It provides two write ports, `NUM_RD` combinational read ports, per-register busy bits for tracking in-flight producers, and a registered count of busy registers. It sits between decode (read and issue) and writeback (two retire lanes).

## Interface

**Parameters**
- `DATA_WIDTH`, 32: register width in bits.
- `ADDR_WIDTH`, 5: address width; depth = 2**ADDR_WIDTH.
- `NUM_RD`, 2: number of read ports (1..8).

**Ports**
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  synchronous, active-low reset (`rst == 0` resets at the clock edge).
- `wen0`, `wen1`  input  1  write enables for lanes 0 and 1.
- `waddr0`, `waddr1`  input  ADDR_WIDTH  write addresses.
- `wdata0`, `wdata1`  input  DATA_WIDTH  write data.
- `raddr`  input  NUM_RD*ADDR_WIDTH  packed read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `rdata`  output  NUM_RD*DATA_WIDTH  packed read data, same slicing.
- `rbusy`  output  NUM_RD  busy flag of each read address.
- `issue_en`  input  1  mark `issue_addr` busy (new producer issued).
- `issue_addr`  input  ADDR_WIDTH  destination register being issued.
- `busy_cnt`  output  ADDR_WIDTH+1  registered count of busy registers.

## Operation

- **Register 0:** reads as 0 and is never busy. Writes and issues to address 0 are ignored.
- **Write:** on a clock edge with `rst == 1`, `wen0` writes `wdata0` to `waddr0` and `wen1` writes `wdata1` to `waddr1`. If both lanes target the same non-zero address, lane 1 wins.
- **Busy clear:** an enabled write to address a clears `busy[a]`.
- **Busy set:** `issue_en` sets `busy[issue_addr]`. If an issue and a write target the same address in the same cycle, busy ends set (the new producer dominates).
- **Reads:** `rdata` slice i is `reg[raddr_i]`, or 0 for address 0. `rbusy[i]` is `busy[raddr_i]`. Both are combinational.
- **busy_cnt:**
  - Next value = current − (number of distinct addresses whose busy bit is actually cleared) + (1 if a busy bit goes 0→1).
  - Re-issuing an already busy register adds nothing.
  - Writing a non-busy register subtracts nothing.
  - The count always equals the popcount of `busy[]`, range 0..2**ADDR_WIDTH−1.
- **Reset** (`rst == 0` at an edge):
  - All registers, all busy bits and `busy_cnt` become 0.
  - Writes and issues in that cycle are ignored.

## Timing

- Write latency is 1 cycle: data written at edge N is visible on `rdata` immediately after edge N (without bypass).
- Read latency is 0 cycles (combinational from `raddr` and state).
- `busy_cnt` reflects the busy state after the same edge; it has no extra lag.
- Reset values: `busy_cnt = 0`, `rbusy = 0`, `rdata = 0` for every address after the first reset edge.
- Contents before the first reset are undefined. The bench must reset first.

## Configuration

- **`REG_FILE_BYPASS_EN` defined:**
  - Same-cycle write-to-read forwarding. If read port i addresses a non-zero register being written this cycle, `rdata` slice i = that write data (lane 1 over lane 0).
  - `rbusy[i]` = 0 for that address unless it is still busy from before and is not being written.
  - Forwarding is suppressed while `rst == 0`.
- **Not defined:** reads see only the stored array and stored busy bits. Same-cycle writes become visible after the edge.

## Test plan

- **Reset, write, read:** hold `rst = 0` for 2 cycles, then write 0xDEADBEEF to r5 via lane 0. Port 0 reads r5 → 0xDEADBEEF after the edge. Port 1 reads r0 → 0. Writing 0x1234 to r0 → r0 still reads 0.
- **Dual-write conflict:** `wen0`/`wen1` both target r7 with 0xAAAA0000 and 0x5555FFFF → r7 = 0x5555FFFF. Distinct targets r3 and r4 → both written in one cycle.
- **Scoreboard:**
  - Issue r9 → `rbusy` = 1 and `busy_cnt` = 1.
  - Issue r9 again → `busy_cnt` stays 1.
  - Write r9 → `rbusy` = 0 and `busy_cnt` = 0.
  - Issue r9 and write r9 in the same cycle → busy stays 1.
- **Double retire:** with r2 and r6 busy (`busy_cnt` = 2), write both lanes in one cycle while issuing r8 → `busy_cnt` = 1, only r8 busy.
- **Bypass:**
  - With `REG_FILE_BYPASS_EN`, write 0xCAFEF00D to r12 while reading r12 in the same cycle → `rdata` = 0xCAFEF00D before the edge.
  - Without the macro → the old value before the edge, the new value after.
- **Reset mid-operation:** with 3 busy registers and r1 = 0x77, assert `rst = 0` together with a write to r1 and an issue of r4 → after the edge, r1 = 0, all `rbusy` = 0, `busy_cnt` = 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with integrated busy scoreboard.
// Two write lanes (lane 1 wins on a same-address conflict), NUM_RD combinational
// read ports, per-register busy bits and a registered busy-register count.
// Register 0 reads as zero, is never busy, and ignores writes and issues.
// Optional macro REG_FILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module reg_file_mp #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_RD     = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wen0,
   input  logic                         wen1,
   input  logic [ADDR_WIDTH-1:0]        waddr0,
   input  logic [ADDR_WIDTH-1:0]        waddr1,
   input  logic [DATA_WIDTH-1:0]        wdata0,
   input  logic [DATA_WIDTH-1:0]        wdata1,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
   output logic [NUM_RD-1:0]            rbusy,
   input  logic                         issue_en,
   input  logic [ADDR_WIDTH-1:0]        issue_addr,
   output logic [ADDR_WIDTH:0]          busy_cnt
);

   localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
   localparam int unsigned CNT_W   = ADDR_WIDTH + 1;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0]      busy;

   // Qualified write / issue strobes (address 0 is inert)
   logic wr0, wr1, iss;
   logic dec0, dec1, inc;
   logic [DEPTH-1:0] busy_next;
   logic [CNT_W-1:0] cnt_next;

   // Decode effective writes/issue and the busy-bit / count updates
   always_comb begin
      wr0 = wen0 && (waddr0 != '0);
      wr1 = wen1 && (waddr1 != '0);
      iss = issue_en && (issue_addr != '0);

      busy_next = busy;
      if (wr0) busy_next[waddr0] = 1'b0;
      if (wr1) busy_next[waddr1] = 1'b0;
      if (iss) busy_next[issue_addr] = 1'b1;

      // A bit is truly cleared only if it was set, is written, and is not re-issued;
      // lane 1 is not counted again when it targets the same address as lane 0.
      dec0 = wr0 && busy[waddr0] && !(iss && (issue_addr == waddr0));
      dec1 = wr1 && busy[waddr1] && !(wr0 && (waddr0 == waddr1))
                 && !(iss && (issue_addr == waddr1));
      inc  = iss && !busy[issue_addr];

      cnt_next = busy_cnt - CNT_W'(dec0) - CNT_W'(dec1) + CNT_W'(inc);
   end

   // Register array: synchronous reset clears every entry, lane 1 written last
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (wr0) mem[waddr0] <= wdata0;
         if (wr1) mem[waddr1] <= wdata1;
      end
   end

   // Busy bits and busy count
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_next;
         busy_cnt <= cnt_next;
      end
   end

   // Combinational read ports (optionally forwarding same-cycle writes)
   always_comb begin
      logic [ADDR_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] d;
      logic                  b;
      rdata = '0;
      rbusy = '0;
      a     = '0;
      d     = '0;
      b     = 1'b0;
      for (int i = 0; i < int'(NUM_RD); i++) begin
         a = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
         if (a == '0) begin
            d = '0;
            b = 1'b0;
         end else begin
            d = mem[a];
            b = busy[a];
`ifdef REG_FILE_BYPASS_EN
            if (rst) begin
               if (wr1 && (waddr1 == a)) begin
                  d = wdata1;
                  b = 1'b0;
               end else if (wr0 && (waddr0 == a)) begin
                  d = wdata0;
                  b = 1'b0;
               end
            end
`endif
         end
         rdata[i*DATA_WIDTH +: DATA_WIDTH] = d;
         rbusy[i] = b;
      end
   end

endmodule
